// File: rtl/axis_sample_feeder_if.sv
// AXI-Stream bundle (tvalid/tready/tdata/tstrb/tlast) shared by the feeder's
// sample master port and its result slave port.
interface axis_sample_feeder_if #(
  parameter int DATA_WIDTH = 32
);
   logic                    tvalid;
   logic                    tready;
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic                    tlast;

   modport master (output tvalid, tdata, tstrb, tlast, input tready);
   modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/axis_sample_feeder.sv
// Host-side sample feeder: buffers DEPTH samples, streams a packet to the accelerator,
// pulses start and latches the single result beat. Optional FEEDER_TIMEOUT_EN adds a result-wait timeout.
module axis_sample_feeder #(
  parameter int DEPTH          = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  s00_axi_aclk,
   input  logic                  s00_axi_aresetn,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  go,
   input  logic [ADDR_WIDTH:0]   len,
   axis_sample_feeder_if.master  m00_axis,
   axis_sample_feeder_if.slave   s00_axis,
   output logic                  start,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  done,
   output logic                  busy,
   output logic                  err
);

   typedef enum logic [1:0] {IDLE, SEND, KICK, WAIT} state_t;

   localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   LEN_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [ADDR_WIDTH:0]   len_q;
   logic [DATA_WIDTH-1:0] sample_buf [DEPTH];

   logic launch, bad_go, beat, take_result, is_last, len_ok, wr_ok, timeout;

   assign len_ok  = (len != '0) && (len <= DEPTH_W);
   assign wr_ok   = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < DEPTH_W);
   assign is_last = ({1'b0, idx_q} == (len_q - LEN_ONE));
   assign busy    = (state_q != IDLE);

`ifdef FEEDER_TIMEOUT_EN
   localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] wait_cnt_q;

   // Counter idles at zero outside WAIT, so the first WAIT cycle counts as cycle 0.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn)       wait_cnt_q <= '0;
      else if (state_q != WAIT)   wait_cnt_q <= '0;
      else                        wait_cnt_q <= wait_cnt_q + TW'(1);
   end

   assign timeout = (state_q == WAIT) && (wait_cnt_q == TO_LAST);
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   // Result-port tlast and tstrb carry no information for a single-beat result.
   logic unused_rx;
   assign unused_rx = ^{s00_axis.tlast, s00_axis.tstrb};

   // NOTE: the sample buffer is plain storage with no reset; clearing it would
   // only cost a reset network, and software always loads it before go.
   always_ff @(posedge s00_axi_aclk) begin
      if (wr_ok) sample_buf[wr_addr] <= wr_data;
   end

   // NOTE: every variable assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d          = state_q;
      launch           = 1'b0;
      bad_go           = 1'b0;
      beat             = 1'b0;
      take_result      = 1'b0;
      m00_axis.tvalid  = 1'b0;
      m00_axis.tlast   = 1'b0;
      start            = 1'b0;
      s00_axis.tready  = 1'b0;

      case (state_q)
         IDLE: begin
            if (go) begin
               if (len_ok) begin
                  launch  = 1'b1;
                  state_d = SEND;
               end else begin
                  bad_go  = 1'b1;
               end
            end
         end
         SEND: begin
            m00_axis.tvalid = 1'b1;
            m00_axis.tlast  = is_last;
            if (m00_axis.tready) begin
               beat = 1'b1;
               if (is_last) state_d = KICK;
            end
         end
         KICK: begin
            start   = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            s00_axis.tready = 1'b1;
            // A result arriving on the timeout cycle still counts as success.
            if (s00_axis.tvalid) begin
               take_result = 1'b1;
               state_d     = IDLE;
            end else if (timeout) begin
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign m00_axis.tdata = (state_q == SEND) ? sample_buf[idx_q] : '0;
   assign m00_axis.tstrb = '1;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         result  <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (launch) begin
            idx_q <= '0;
            len_q <= len;
            done  <= 1'b0;
            err   <= 1'b0;
         end else if (beat) begin
            idx_q <= idx_q + IDX_ONE;
         end
         if (bad_go) err <= 1'b1;
         if (take_result) begin
            result <= s00_axis.tdata;
            done   <= 1'b1;
         end else if (timeout) begin
            err    <= 1'b1;
         end
      end
   end

   a_stall_hold: assert property (@(posedge s00_axi_aclk) disable iff (!s00_axi_aresetn)
      (m00_axis.tvalid && !m00_axis.tready) |=>
         (m00_axis.tvalid && $stable(m00_axis.tdata) && $stable(m00_axis.tlast)));

   a_start_pulse: assert property (@(posedge s00_axi_aclk) disable iff (!s00_axi_aresetn)
      start |=> !start);

endmodule

// File: tb/tb_axis_sample_feeder.sv
// Scoreboard bench for axis_sample_feeder: a sample-array model predicts every
// beat and result; monitors compare whatever the DUT presents.
module tb_axis_sample_feeder;
   localparam int DEPTH = 10;
   localparam int DW    = 32;
   localparam int AW    = 4;
`ifdef FEEDER_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1024;
`endif

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          go = 1'b0;
   logic [AW:0]   len = '0;
   logic          start, done, busy, err;
   logic [DW-1:0] result;

   axis_sample_feeder_if #(.DATA_WIDTH(DW)) m_if ();
   axis_sample_feeder_if #(.DATA_WIDTH(DW)) s_if ();

   axis_sample_feeder #(
      .DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .s00_axi_aclk(aclk), .s00_axi_aresetn(aresetn),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .go(go), .len(len),
      .m00_axis(m_if), .s00_axis(s_if),
      .start(start), .result(result), .done(done), .busy(busy), .err(err)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   int            last_hs_cyc = -10;
   beat_t         exp_q[$];
   logic [DW-1:0] exp_res_q[$];
   logic [DW-1:0] model_buf [DEPTH];
   bit            stalled = 1'b0;
   beat_t         held;
   logic          done_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(posedge aclk) cyc <= cyc + 1;

   // Beat / result monitor.
   always @(negedge aclk) begin
      if (aresetn) begin
         if (stalled && m_if.tvalid) begin
            check("stall_hold_data", m_if.tdata, held.data);
            check("stall_hold_last", m_if.tlast, held.last);
         end
         if (m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_if.tdata);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("beat_data", m_if.tdata, e.data);
               check("beat_last", m_if.tlast, e.last);
            end
            if (m_if.tlast) last_hs_cyc = cyc;
         end
         stalled   = m_if.tvalid && !m_if.tready;
         held.data = m_if.tdata;
         held.last = m_if.tlast;
         if (done && !done_prev) begin
            if (exp_res_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: got result 0x%0h, expected none", result);
            end else begin
               check("result_value", result, exp_res_q.pop_front());
            end
         end
      end else begin
         stalled = 1'b0;
      end
      done_prev = done;
   end

   task automatic write_sample(input int addr, input logic [DW-1:0] data);
      @(posedge aclk); #1;
      wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
      if (addr < DEPTH) model_buf[addr] = data;
      @(posedge aclk); #1;
      wr_en = 1'b0;
   endtask

   task automatic push_exp(input int n);
      for (int i = 0; i < n; i++) begin
         beat_t b;
         b.data = model_buf[i];
         b.last = (i == n - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic launch(input int n);
      @(posedge aclk); #1;
      go = 1'b1; len = (AW+1)'(n);
      @(posedge aclk); #1;
      go = 1'b0;
   endtask

   // mode 0: always ready, 1: toggle, 2: random. Returns at the negedge where start is seen.
   task automatic stream(input int mode, input bit poke);
      bit seen = 1'b0;
      for (int c = 0; c < 400; c++) begin
         case (mode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = (c % 2 == 1);
            default: m_if.tready = 1'($urandom_range(0, 1));
         endcase
         if (poke && c == 0) begin
            wr_en = 1'b1; wr_addr = '0; wr_data = 32'hDEADBEEF;
            go = 1'b1; len = (AW+1)'(3);
         end else begin
            wr_en = 1'b0; go = 1'b0;
         end
         @(negedge aclk);
         if (c == 0) begin
            check("first_beat_latency", m_if.tvalid, 1'b1);
            check("go_clears_err", err, 1'b0);
            check("go_clears_done", done, 1'b0);
            check("busy_in_send", busy, 1'b1);
         end
         if (start) begin
            seen = 1'b1;
            check("start_after_last", 64'(cyc), 64'(last_hs_cyc + 1));
            check("beats_before_start", 64'(exp_q.size()), 64'd0);
            break;
         end
         @(posedge aclk); #1;
      end
      wr_en = 1'b0; go = 1'b0;
      m_if.tready = 1'b0;
      if (!seen) check("start_timeout", 1'b0, 1'b1);
   endtask

   task automatic deliver_result(input logic [DW-1:0] res, input int dly);
      @(posedge aclk); #1;
      for (int d = 0; d < dly; d++) begin
         @(negedge aclk);
         check("wait_busy", busy, 1'b1);
         @(posedge aclk); #1;
      end
      s_if.tvalid = 1'b1; s_if.tdata = res; s_if.tlast = 1'b1;
      exp_res_q.push_back(res);
      @(negedge aclk);
      check("kick_one_cycle", start, 1'b0);
      check("result_tready", s_if.tready, 1'b1);
      @(posedge aclk); #1;
      s_if.tvalid = 1'b0;
      @(negedge aclk);
      check("done_set", done, 1'b1);
      check("idle_after_result", busy, 1'b0);
      check("no_err_on_result", err, 1'b0);
   endtask

   task automatic run_packet(input int n, input int mode, input logic [DW-1:0] res, input bit poke);
      push_exp(n);
      launch(n);
      stream(mode, poke);
      deliver_result(res, int'($urandom_range(0, 3)));
   endtask

   task automatic bad_go(input int n);
      launch(n);
      @(negedge aclk);
      check("bad_len_err", err, 1'b1);
      check("bad_len_idle", busy, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         check("bad_len_no_tvalid", m_if.tvalid, 1'b0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tvalid"}, m_if.tvalid, 1'b0);
      check({tag, "_tdata"},  m_if.tdata, '0);
      check({tag, "_tlast"},  m_if.tlast, 1'b0);
      check({tag, "_tstrb"},  m_if.tstrb, 4'hF);
      check({tag, "_start"},  start, 1'b0);
      check({tag, "_s_tready"}, s_if.tready, 1'b0);
      check({tag, "_result"}, result, '0);
      check({tag, "_done"},   done, 1'b0);
      check({tag, "_err"},    err, 1'b0);
      check({tag, "_busy"},   busy, 1'b0);
   endtask

   logic [DW-1:0] float_tab [10] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                     32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                                     32'h41100000, 32'h41200000};

   initial begin
      int n;
      m_if.tready = 1'b0;
      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tstrb = '1;
      for (int i = 0; i < DEPTH; i++) model_buf[i] = '0;

      #12;
      check_all_zero("reset");
      #10 aresetn = 1'b1;

      for (int i = 0; i < 10; i++) write_sample(i, float_tab[i]);
      write_sample(10, 32'hBAD0000A);
      write_sample(15, 32'hBAD0000F);

      // 1.0..10.0 back to back, result 55.0
      run_packet(10, 0, 32'h425C0000, 1'b0);

      // result beats outside WAIT are refused
      @(posedge aclk); #1;
      s_if.tvalid = 1'b1; s_if.tdata = 32'h12345678; s_if.tlast = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         check("idle_s_tready", s_if.tready, 1'b0);
      end
      @(posedge aclk); #1;
      s_if.tvalid = 1'b0;
      @(negedge aclk);
      check("idle_result_kept", result, 32'h425C0000);
      check("done_sticky", done, 1'b1);

      // toggling tready, plus write and go attempts while busy
      run_packet(10, 1, 32'h3F000000, 1'b1);
      run_packet(2, 0, 32'h40490FDB, 1'b0);

      bad_go(0);
      bad_go(11);
      bad_go(31);

      for (int k = 0; k < 6; k++) begin
         for (int w = 0; w < 3; w++)
            write_sample(int'($urandom_range(0, 15)), $urandom);
         run_packet(int'($urandom_range(1, DEPTH)), 2, $urandom, 1'b0);
      end

      // reset after 4 beats, then a full resend from index 0
      push_exp(10);
      launch(10);
      m_if.tready = 1'b1;
      n = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge aclk);
         if (m_if.tvalid && m_if.tready) n++;
         if (n == 4) break;
         @(posedge aclk); #1;
      end
      check("beats_before_reset", 64'(n), 64'd4);
      #2;
      m_if.tready = 1'b0;
      aresetn = 1'b0;
      #1;
      check_all_zero("async_reset");
      exp_q.delete();
      @(negedge aclk); #1;
      aresetn = 1'b1;
      run_packet(10, 0, 32'h41A00000, 1'b0);

`ifdef FEEDER_TIMEOUT_EN
      push_exp(3);
      launch(3);
      stream(0, 1'b0);
      n = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge aclk); #1;
         @(negedge aclk);
         if (busy) n++;
         else break;
      end
      check("timeout_wait_cycles", 64'(n), 64'(TO));
      check("timeout_err", err, 1'b1);
      check("timeout_done", done, 1'b0);

      push_exp(3);
      launch(3);
      stream(0, 1'b0);
      @(posedge aclk); #1;
      repeat (TO - 1) @(posedge aclk);
      #1;
      s_if.tvalid = 1'b1; s_if.tdata = 32'h40800000; s_if.tlast = 1'b1;
      exp_res_q.push_back(32'h40800000);
      @(posedge aclk); #1;
      s_if.tvalid = 1'b0;
      @(negedge aclk);
      check("timeout_tie_done", done, 1'b1);
      check("timeout_tie_err", err, 1'b0);
      check("timeout_tie_idle", busy, 1'b0);
`else
      push_exp(3);
      launch(3);
      stream(0, 1'b0);
      repeat (40) @(posedge aclk);
      @(negedge aclk);
      check("wait_holds_busy", busy, 1'b1);
      check("wait_holds_tready", s_if.tready, 1'b1);
      check("wait_holds_no_err", err, 1'b0);
      deliver_result(32'h40800000, 0);
`endif

      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("beats_drained", 64'(exp_q.size()), 64'd0);
      check("results_drained", 64'(exp_res_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
